hazard_ctrl_unit: RTL
=====================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline sequencer for the 5-stage RISC-V core. It works alongside forwarding_unit.
//  - Detects load-use hazards that forwarding cannot cover, and stalls for them.
//  - Squashes wrong-path instructions when a branch resolves taken in EX.
//  - Freezes the front of the pipe while the multi-cycle MUL/DIV unit occupies EX.
//  - Drives the PC and IF/ID, ID/EX and EX/MEM register write-enables, flushes and bubbles.
// PARAMETERS
//  MD_LATENCY  4   cycles MUL/DIV occupies EX, counting the start cycle (legal range 2..16)
//  CNT_W       32  width of the perf counters (used only with HAZ_PERF_CNT_EN)
// PORTS
//  clk              in   1  core clock; all state updates on the rising edge
//  rst_n            in   1  asynchronous, active-low reset
//  if_id_rs1        in   5  rs1 of the instruction in ID
//  if_id_rs2        in   5  rs2 of the instruction in ID
//  id_uses_rs1      in   1  the ID instruction reads rs1
//  id_uses_rs2      in   1  the ID instruction reads rs2
//  id_ex_rd         in   5  rd of the instruction in EX
//  id_ex_memread    in   1  the instruction in EX is a load
//  ex_branch_taken  in   1  branch/jump in EX resolved taken (redirect)
//  ex_muldiv_start  in   1  a MUL/DIV instruction is in EX in its first cycle
//  pc_write         out  1  PC update enable
//  if_id_write      out  1  IF/ID register load enable
//  if_id_flush      out  1  IF/ID becomes a NOP on the next edge
//  id_ex_write      out  1  ID/EX register load enable
//  id_ex_flush      out  1  ID/EX becomes a bubble (control signals zeroed)
//  ex_mem_bubble    out  1  EX/MEM captures a bubble instead of the EX result
//  md_busy          out  1  FSM is in MD_BUSY
//  perf_stall_cnt   out  CNT_W  stall-cycle count (only with HAZ_PERF_CNT_EN)
//  perf_flush_cnt   out  CNT_W  flush-event count (only with HAZ_PERF_CNT_EN)
// BEHAVIOUR
//  Reset (rst_n=0, effective immediately)
//  - State goes to RUN and md_cnt to 0.
//  - Outputs are forced, overriding the rules below: pc_write=0, if_id_write=0, id_ex_write=0,
//    if_id_flush=1, id_ex_flush=1, ex_mem_bubble=1, md_busy=0.
//  Outputs are combinational from state and inputs: zero-cycle latency to the pipe registers.
//  FSM states: RUN, MD_BUSY. A 4-bit md_cnt counts down inside MD_BUSY.
//  Default outputs in RUN
//  - All write-enables 1; all flushes and ex_mem_bubble 0.
//  Load-use hazard (RUN only)
//  - Condition: id_ex_memread && id_ex_rd!=0 && ((id_uses_rs1 && id_ex_rd==if_id_rs1) ||
//    (id_uses_rs2 && id_ex_rd==if_id_rs2)).
//  - Response: pc_write=0, if_id_write=0, id_ex_flush=1.
//  - The stall is exactly one cycle; on the next cycle the load is in MEM and the hazard clears.
//  Branch taken (RUN only)
//  - Response: if_id_flush=1, id_ex_flush=1; pc_write=1 so the PC takes the redirect.
//  - Branch overrides load-use: the stalled ID instruction is wrong-path.
//  MUL/DIV start: ex_muldiv_start=1 in RUN
//  - Outputs: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
//  - Next state MD_BUSY, md_cnt loads MD_LATENCY-2.
//  MD_BUSY
//  - Outputs: pc_write, if_id_write and id_ex_write held at 0; ex_mem_bubble=1; md_busy=1.
//  - If md_cnt != 0, md_cnt decrements each cycle.
//  - If md_cnt == 0: ex_mem_bubble=0 and id_ex_write=1 (result captured by EX/MEM); next state RUN.
//  - ex_branch_taken, ex_muldiv_start and the load-use condition are ignored in MD_BUSY.
//  Simultaneous ex_branch_taken && ex_muldiv_start in RUN
//  - Illegal. Branch wins and the FSM stays in RUN; the bench flags it with an assertion.
//  Total stall for one MUL/DIV is MD_LATENCY cycles; back-to-back MUL/DIVs re-enter MD_BUSY from RUN.
//  Reset asserted mid-MD_BUSY: state immediately returns to RUN; no partial result is released.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined
//  - Adds perf_stall_cnt and perf_flush_cnt, both reset to 0.
//  - perf_stall_cnt increments every cycle with pc_write=0 and rst_n=1.
//  - perf_flush_cnt increments every cycle with if_id_flush=1 and rst_n=1.
//  - Both counters saturate at all-ones.
//  HAZ_PERF_CNT_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1 Load-use: id_ex_memread=1, id_ex_rd=5, if_id_rs1=5, id_uses_rs1=1
//    -> one cycle with pc_write=0, if_id_write=0, id_ex_flush=1; next cycle (memread=0) all enables 1.
//  2 x0 and unused operands:
//    - id_ex_rd=0, if_id_rs1=0 -> no stall.
//    - id_ex_rd=7, if_id_rs2=7, id_uses_rs2=0 -> no stall.
//  3 Branch over load-use: load-use condition true and ex_branch_taken=1
//    -> pc_write=1, if_id_flush=1, id_ex_flush=1, if_id_write=1.
//  4 MUL/DIV, MD_LATENCY=4: ex_muldiv_start pulse
//    -> pc_write=0 for exactly 4 cycles; ex_mem_bubble=1 for 3 cycles then 0 on the 4th;
//       md_busy=1 for cycles 2-4; RUN on cycle 5.
//  5 Reset mid-MD_BUSY (cycle 2)
//    -> md_busy=0 and flushes=1 immediately; after release, RUN with all enables 1 and md_cnt=0.
//  6 HAZ_PERF_CNT_EN: tests 1, 3 and 4 in sequence
//    -> perf_stall_cnt=5, perf_flush_cnt=1; preload to all-ones -> counters hold.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencer: load-use stalls, taken-branch squashes and MUL/DIV freeze for the 5-stage core.
// Optional perf counters are compiled in with `define HAZ_PERF_CNT_EN.
module hazard_ctrl_unit #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [4:0] if_id_rs1,
   input  logic [4:0] if_id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] id_ex_rd,
   input  logic       id_ex_memread,
   input  logic       ex_branch_taken,
   input  logic       ex_muldiv_start,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_id_flush,
   output logic       id_ex_write,
   output logic       id_ex_flush,
   output logic       ex_mem_bubble,
   output logic       md_busy
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

   localparam logic [0:0] RUN     = 1'b0;
   localparam logic [0:0] MD_BUSY = 1'b1;
   // The start cycle and the release cycle are both part of the stall, hence the -2.
   localparam logic [3:0] MD_LOAD = 4'(MD_LATENCY - 2);

   logic [0:0] state, state_nxt;
   logic [3:0] md_cnt, md_cnt_nxt;
   logic       load_use;

   assign load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                     ((id_uses_rs1 && (id_ex_rd == if_id_rs1)) ||
                      (id_uses_rs2 && (id_ex_rd == if_id_rs2)));

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_write   = 1'b1;
      id_ex_flush   = 1'b0;
      ex_mem_bubble = 1'b0;
      md_busy       = 1'b0;
      state_nxt     = state;
      md_cnt_nxt    = md_cnt;
      if (!rst_n) begin
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_write   = 1'b0;
         if_id_flush   = 1'b1;
         id_ex_flush   = 1'b1;
         ex_mem_bubble = 1'b1;
         state_nxt     = RUN;
         md_cnt_nxt    = 4'd0;
      end else begin
         case (state)
            RUN: begin
               // A taken branch makes both a stalled ID op and a MUL/DIV start wrong-path.
               if (ex_branch_taken) begin
                  if_id_flush = 1'b1;
                  id_ex_flush = 1'b1;
               end else if (ex_muldiv_start) begin
                  pc_write      = 1'b0;
                  if_id_write   = 1'b0;
                  id_ex_write   = 1'b0;
                  ex_mem_bubble = 1'b1;
                  state_nxt     = MD_BUSY;
                  md_cnt_nxt    = MD_LOAD;
               end else if (load_use) begin
                  pc_write    = 1'b0;
                  if_id_write = 1'b0;
                  id_ex_flush = 1'b1;
               end
            end
            MD_BUSY: begin
               pc_write      = 1'b0;
               if_id_write   = 1'b0;
               id_ex_write   = 1'b0;
               ex_mem_bubble = 1'b1;
               md_busy       = 1'b1;
               if (md_cnt == 4'd0) begin
                  ex_mem_bubble = 1'b0;
                  id_ex_write   = 1'b1;
                  state_nxt     = RUN;
               end else begin
                  md_cnt_nxt = md_cnt - 4'd1;
               end
            end
            default: begin
               state_nxt  = RUN;
               md_cnt_nxt = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= RUN;
         md_cnt <= 4'd0;
      end else begin
         state  <= state_nxt;
         md_cnt <= md_cnt_nxt;
      end
   end

`ifdef HAZ_PERF_CNT_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (!pc_write)
            perf_stall_cnt <= sat_inc(perf_stall_cnt);
         if (if_id_flush)
            perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = ^CNT_W;
`endif

endmodule
